// File: rtl/mem_responder.sv
// mem_responder: single-port word memory behind a request/response handshake.
// Writes complete in the accept cycle; reads pass IDLE -> READ -> RESP and are
// held in RESP until the initiator takes them. Out-of-range accesses set a
// sticky ERR; out-of-range reads return zero, out-of-range writes are dropped.
module mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RECEIVE_ADDR_VALID,
  input  logic [31:0] RECEIVE_ADDR,
  input  logic        RECEIVE_DATA_VALID,
  input  logic [31:0] RECEIVE_DATA,
  output logic        RECEIVE_READY,
  output logic        SEND_VALID,
  output logic [31:0] SEND_DATA,
  input  logic        SEND_READY,
  output logic        ERR
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_q;
  logic          ready_q;
  logic          send_valid_q;
  logic [31:0]   send_data_q;
  logic          err_q;
  logic [AW-1:0] rd_idx_q;
  logic          rd_hit_q;

  // Storage is deliberately not reset; words are undefined until written.
  logic [31:0]   mem_q [DEPTH_WORDS];

  logic [31:0]   word_idx_s;
  logic          addr_hit_s;
  logic          accept_s;
  logic          wr_en_s;

  // Word index is taken modulo 2^32, so addresses below the base turn into
  // huge indices; the explicit lower-bound test keeps them from aliasing.
  assign word_idx_s = (RECEIVE_ADDR - BASE_ADDR) >> 2'd2;
  assign addr_hit_s = (RECEIVE_ADDR >= BASE_ADDR) && (word_idx_s < DEPTH_WORDS);

  // ready_q is only ever high in IDLE, so it alone qualifies acceptance.
  assign accept_s = ready_q & RECEIVE_ADDR_VALID;
  assign wr_en_s  = accept_s & RECEIVE_DATA_VALID & addr_hit_s;

  // Memory write port: in-range writes land at the accepting edge.
  always_ff @(posedge CLK) begin
    if (wr_en_s) begin
      mem_q[word_idx_s[AW-1:0]] <= RECEIVE_DATA;
    end
  end

  // Request/response FSM with all outputs registered.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      ready_q      <= 1'b0;
      send_valid_q <= 1'b0;
      send_data_q  <= 32'h0000_0000;
      err_q        <= 1'b0;
      rd_idx_q     <= '0;
      rd_hit_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (accept_s) begin
            if (!addr_hit_s) begin
              err_q <= 1'b1;
            end
            if (!RECEIVE_DATA_VALID) begin
              state_q  <= READ;
              ready_q  <= 1'b0;
              rd_idx_q <= word_idx_s[AW-1:0];
              rd_hit_q <= addr_hit_s;
            end
          end
        end
        READ: begin
          // Synchronous RAM access; a write accepted the cycle before the
          // read is already in the array here.
          state_q      <= RESP;
          send_valid_q <= 1'b1;
          send_data_q  <= rd_hit_q ? mem_q[rd_idx_q] : 32'h0000_0000;
        end
        RESP: begin
          if (SEND_READY) begin
            state_q      <= IDLE;
            send_valid_q <= 1'b0;
            ready_q      <= 1'b1;
          end
        end
        default: begin
          state_q      <= IDLE;
          ready_q      <= 1'b0;
          send_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign RECEIVE_READY = ready_q;
  assign SEND_VALID    = send_valid_q;
  assign SEND_DATA     = send_data_q;
  assign ERR           = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: vector table, hand-written multi-cycle sequences
// and a randomized phase checked against an address-map model.
module tb_mem_responder;

  localparam logic [31:0] BASE  = 32'h2000_0000;
  localparam int unsigned DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rav = 1'b0;
  logic [31:0] ra  = 32'h0;
  logic        dv  = 1'b0;
  logic [31:0] rd  = 32'h0;
  logic        rr;
  logic        sv;
  logic [31:0] sd;
  logic        sr  = 1'b1;
  logic        err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: written words keyed by word number, plus sticky error.
  logic [31:0] model_mem [int unsigned];
  logic        err_m = 1'b0;

  typedef struct {
    logic        rst_before;
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vt [14];

  mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
    .CLK                (clk),
    .RST                (rst),
    .RECEIVE_ADDR_VALID (rav),
    .RECEIVE_ADDR       (ra),
    .RECEIVE_DATA_VALID (dv),
    .RECEIVE_DATA       (rd),
    .RECEIVE_READY      (rr),
    .SEND_VALID         (sv),
    .SEND_DATA          (sd),
    .SEND_READY         (sr),
    .ERR                (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // In range when the byte address lies in [BASE, BASE + 4*DEPTH).
  function automatic logic in_range_m(input logic [31:0] a);
    longint unsigned la;
    longint unsigned lo;
    longint unsigned hi;
    la = {32'h0, a};
    lo = {32'h0, BASE};
    hi = lo + 64'd4 * DEPTH;
    return (la >= lo) && (la < hi);
  endfunction

  function automatic int unsigned key_m(input logic [31:0] a);
    return (a - BASE) / 32'd4;
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (!rr && n < 50) begin
      tick();
      n++;
    end
    chk1("ready_wait", rr, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk1("rst_valid", sv, 1'b0);
    chk32("rst_data", sd, 32'h0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_ready", rr, 1'b0);
    tick();
    tick();
    @(negedge clk);
    rst   = 1'b1;
    err_m = 1'b0;
    tick();
    chk1("rst_release_ready", rr, 1'b1);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
    wait_ready();
    rav = 1'b1; dv = 1'b1; ra = addr; rd = data;
    tick();
    rav = 1'b0; dv = 1'b0; ra = $urandom; rd = $urandom;
    if (in_range_m(addr)) model_mem[key_m(addr)] = data;
    else                  err_m = 1'b1;
    chk1("wr_err", err, err_m);
    chk1("wr_ready_next", rr, 1'b1);
  endtask

  // Read with SEND_READY held low for 'hold' cycles of RESP; during the hold
  // a stray write request is presented and must be ignored.
  task automatic do_read(input logic [31:0] addr, input int hold,
                         output logic [31:0] data, output int acc);
    int lat;
    wait_ready();
    rav = 1'b1; dv = 1'b0; ra = addr; sr = (hold == 0);
    tick();
    acc = cyc;
    rav = 1'b0; ra = $urandom;
    if (!in_range_m(addr)) err_m = 1'b1;
    chk1("rd_ready_low", rr, 1'b0);
    // Valid is first visible after the edge following accept, so it is
    // sampled high at the second edge after accept.
    lat = 1;
    while (!sv && lat < 20) begin
      tick();
      lat++;
    end
    chk32("rd_latency", lat, 32'd2);
    data = sd;
    for (int i = 0; i < hold; i++) begin
      chk1("bp_valid", sv, 1'b1);
      chk32("bp_data", sd, data);
      chk1("bp_ready", rr, 1'b0);
      rav = 1'b1; dv = 1'b1; ra = BASE + 32'h10; rd = 32'hDEAD_BEEF;
      tick();
    end
    rav = 1'b0; dv = 1'b0;
    if (hold > 0) begin
      chk1("bp_valid_end", sv, 1'b1);
      chk32("bp_data_end", sd, data);
    end
    sr = 1'b1;
    tick();
    chk1("hs_ready", rr, 1'b1);
    chk1("hs_valid", sv, 1'b0);
    chk1("rd_err", err, err_m);
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] a;
    logic [31:0] bd [6];
    int          acc;
    int          prev_acc;

    // rst_before, is_wr, addr, wdata, exp_data, exp_err
    vt[0]  = '{1'b0, 1'b1, 32'h2000_0010, 32'hCAFE_0001, 32'h0000_0000, 1'b0};
    vt[1]  = '{1'b0, 1'b0, 32'h2000_0010, 32'h0000_0000, 32'hCAFE_0001, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 32'h2000_0023, 32'h1234_5678, 32'h0000_0000, 1'b0};
    vt[3]  = '{1'b0, 1'b0, 32'h2000_0020, 32'h0000_0000, 32'h1234_5678, 1'b0};
    vt[4]  = '{1'b0, 1'b1, 32'h2000_0FFC, 32'hA5A5_0FFC, 32'h0000_0000, 1'b0};
    vt[5]  = '{1'b0, 1'b0, 32'h2000_0FFC, 32'h0000_0000, 32'hA5A5_0FFC, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 32'h2000_0000, 32'h0000_1111, 32'h0000_0000, 1'b0};
    vt[7]  = '{1'b0, 1'b0, 32'h2000_0001, 32'h0000_0000, 32'h0000_1111, 1'b0};
    vt[8]  = '{1'b0, 1'b0, 32'h2000_1000, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vt[9]  = '{1'b1, 1'b0, 32'h1FFF_FFFC, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vt[10] = '{1'b1, 1'b1, 32'h2000_1000, 32'hDEAD_0000, 32'h0000_0000, 1'b1};
    vt[11] = '{1'b0, 1'b0, 32'h2000_0000, 32'h0000_0000, 32'h0000_1111, 1'b1};
    vt[12] = '{1'b1, 1'b1, 32'h1FFF_FFFC, 32'hDEAD_0001, 32'h0000_0000, 1'b1};
    vt[13] = '{1'b0, 1'b0, 32'h2000_0FFC, 32'h0000_0000, 32'hA5A5_0FFC, 1'b1};

    #2;
    do_reset();

    // Vector table.
    for (int i = 0; i < 14; i++) begin
      if (vt[i].rst_before) do_reset();
      if (vt[i].is_wr) begin
        do_write(vt[i].addr, vt[i].wdata);
        chk1("vec_wr_err", err, vt[i].exp_err);
      end else begin
        do_read(vt[i].addr, 0, d, acc);
        chk32("vec_rd_data", d, vt[i].exp_data);
        chk1("vec_rd_err", err, vt[i].exp_err);
      end
    end

    // Burst: six writes then six reads with SEND_READY held high.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      bd[i] = $urandom;
      do_write(32'h2000_0100 + 32'(4 * i), bd[i]);
    end
    prev_acc = 0;
    for (int i = 0; i < 6; i++) begin
      do_read(32'h2000_0100 + 32'(4 * i), 0, d, acc);
      chk32("burst_data", d, bd[i]);
      if (i > 0) chk32("burst_spacing", acc - prev_acc, 32'd3);
      prev_acc = acc;
    end

    // Backpressure: response held for five cycles; stray write ignored.
    do_read(32'h2000_0010, 5, d, acc);
    chk32("bp_read_data", d, 32'hCAFE_0001);
    do_read(32'h2000_0010, 0, d, acc);
    chk32("bp_no_side_effect", d, 32'hCAFE_0001);
    chk1("bp_err", err, 1'b0);

    // Reset while a read response is pending.
    do_write(32'h2000_0040, 32'h7777_0040);
    wait_ready();
    rav = 1'b1; dv = 1'b0; ra = 32'h2000_0040; sr = 1'b0;
    tick();
    rav = 1'b0;
    tick();
    chk1("mid_rst_pre_valid", sv, 1'b1);
    rst = 1'b0;
    #1;
    chk1("mid_rst_valid", sv, 1'b0);
    chk1("mid_rst_ready", rr, 1'b0);
    tick();
    @(negedge clk);
    rst   = 1'b1;
    err_m = 1'b0;
    sr    = 1'b1;
    tick();
    chk1("mid_rst_release_ready", rr, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk1("mid_rst_no_resp", sv, 1'b0);
      tick();
    end

    // Randomized phase against the model.
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0:       a = BASE + 32'(4 * DEPTH) + $urandom_range(0, 15);
        1:       a = BASE - 32'd1 - $urandom_range(0, 15);
        2:       a = $urandom;
        3:       a = BASE + 32'(4 * (DEPTH - 4)) + $urandom_range(0, 15);
        default: a = BASE + $urandom_range(0, 63);
      endcase
      if ($urandom_range(0, 39) == 0) do_reset();
      if ($urandom_range(0, 1) == 0) begin
        do_write(a, $urandom);
      end else begin
        do_read(a, int'($urandom_range(0, 2)), d, acc);
        if (!in_range_m(a))                 chk32("rand_oor_data", d, 32'h0);
        else if (model_mem.exists(key_m(a))) chk32("rand_rd_data", d, model_mem[key_m(a)]);
      end
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL provide parameter BASE_ADDR, default 32'h2000_0000: byte address of word 0.
REQ-002 SHALL provide parameter DEPTH_WORDS, default 1024: number of 32-bit words stored; power of two, at least 2.
REQ-003 SHALL provide port CLK  input  1  single clock; all state on rising edge.
REQ-004 SHALL provide port RST  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL provide port RECEIVE_ADDR_VALID  input  1  request byte address valid.
REQ-006 SHALL provide port RECEIVE_ADDR  input  32  request byte address.
REQ-007 SHALL provide port RECEIVE_DATA_VALID  input  1  request carries write data; qualified by RECEIVE_ADDR_VALID.
REQ-008 SHALL provide port RECEIVE_DATA  input  32  write data.
REQ-009 SHALL provide port RECEIVE_READY  output  1  request accept.
REQ-010 SHALL provide port SEND_VALID  output  1  read response valid.
REQ-011 SHALL provide port SEND_DATA  output  32  read response data.
REQ-012 SHALL provide port SEND_READY  input  1  response accept from initiator.
REQ-013 SHALL provide port ERR  output  1  sticky out-of-range flag.

Function
REQ-014 SHALL implement FSM states IDLE, READ, RESP; RECEIVE_READY = 1 only in IDLE, decoded from registered state with no combinational path from inputs.
REQ-015 SHALL treat a request as accepted on a rising edge with RECEIVE_ADDR_VALID & RECEIVE_READY both 1.
REQ-016 SHALL treat an accepted request with RECEIVE_DATA_VALID = 1 as a write: RECEIVE_DATA stored at that edge, no response, state stays IDLE, next request acceptable the following cycle.
REQ-017 SHALL treat an accepted request with RECEIVE_DATA_VALID = 0 as a read: IDLE -> READ (synchronous RAM access) -> RESP.
REQ-018 SHALL assert SEND_VALID in RESP only, with read latency of exactly 2 cycles: accepted at edge k, SEND_VALID high from edge k+2.
REQ-019 SHALL hold SEND_VALID and SEND_DATA stable in RESP until SEND_READY = 1 at a rising edge, then go RESP -> IDLE; RECEIVE_READY high in the following cycle.
REQ-020 SHALL compute word index = (RECEIVE_ADDR - BASE_ADDR) >> 2 in 32-bit unsigned arithmetic; RECEIVE_ADDR[1:0] ignored.
REQ-021 SHALL deem an address in range iff RECEIVE_ADDR >= BASE_ADDR and word index < DEPTH_WORDS; no wrap-around into the array.
REQ-022 SHALL drop an out-of-range write with memory unchanged and set ERR.
REQ-023 SHALL still complete an out-of-range read with normal latency, return SEND_DATA = 32'h0000_0000, and set ERR.
REQ-024 SHALL keep ERR set until reset.
REQ-025 SHALL return the most recently written value for a read to any address, including a read accepted the cycle after the write.
REQ-026 SHALL ignore RECEIVE_* inputs in READ and RESP, with no capture and no side effects.
REQ-027 SHALL hold SEND_DATA at its last value outside RESP; its value there is don't-care for checking.

Reset
REQ-028 SHALL, while RST = 0, immediately force state IDLE, SEND_VALID 0, SEND_DATA 0, ERR 0, and RECEIVE_READY 0.
REQ-029 SHALL raise RECEIVE_READY to 1 in the first cycle after RST deasserts.
REQ-030 SHALL discard any pending read when RST is asserted mid-transaction, with no response after reset release.
REQ-031 SHALL not reset memory contents; words are undefined until written.

Verification
REQ-032 SHALL cover write then read: write 32'hCAFE_0001 to 32'h2000_0010, then read 32'h2000_0010 -> SEND_VALID exactly 2 cycles after read accept, SEND_DATA 32'hCAFE_0001, ERR 0.
REQ-033 SHALL cover a burst: write 6 words D0..D5 at 32'h2000_0100 + 4*i, read back in order with SEND_READY held 1 -> each read returns Di, one request accepted every 3 cycles.
REQ-034 SHALL cover backpressure: SEND_READY 0 for 5 cycles during RESP -> SEND_VALID and SEND_DATA stable, RECEIVE_READY 0 throughout, returns to IDLE only after the SEND_READY handshake.
REQ-035 SHALL cover range boundaries: read 32'h1FFF_FFFC -> data 0, ERR 1; after reset, read BASE_ADDR + 4*(DEPTH_WORDS-1) -> ERR 0, and BASE_ADDR + 4*DEPTH_WORDS -> ERR 1.
REQ-036 SHALL cover unaligned access: write 32'h1234_5678 to 32'h2000_0023, read 32'h2000_0020 -> 32'h1234_5678.
REQ-037 SHALL cover reset mid-read: RST low 1 cycle after read accept -> SEND_VALID 0 at once and no response after release; RECEIVE_READY 1 in the first cycle after RST deasserts.
